reg_cmd_master: RTL

- Byte-stream command decoder that acts as the bus master for the miner register file.
- Turns host bytes (from the UART/SPI byte layer) into register reads and writes on the reg_num/reg_write/reg_wdata/reg_rdata port.
- Returns read data as a byte stream.
- Sits between the host link byte FIFO and the register file; it is the only agent driving register addresses.

---
 rtl/reg_cmd_master_if.sv | 24 ++
 rtl/reg_cmd_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_master_if.sv
// Host byte stream and register file bus seen by reg_cmd_master.
// The master modport is the decoder side; slave is the host/register-file side.
interface reg_cmd_master_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [6:0] reg_num;
    logic       reg_write;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rdata,
        output rx_ready, tx_data, tx_valid, reg_num, reg_write, reg_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rdata,
        input  rx_ready, tx_data, tx_valid, reg_num, reg_write, reg_wdata
    );
endinterface

// File: rtl/reg_cmd_master.sv
// Byte-stream command decoder driving the miner register file (write = cmd|0x80 + data, read = cmd -> 1 byte).
// Optional write-data timeout is enabled by defining REG_CMD_TIMEOUT_EN.
module reg_cmd_master #(
    parameter int unsigned MAX_ADDR       = 80,
    parameter int unsigned FIRST_WR_ADDR  = 5,
    parameter logic [7:0]  RD_ERR_BYTE    = 8'hEE,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    reg_cmd_master_if.master bus,
    output logic             busy,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_STROBE,
        RD_ADDR,
        RD_SAMPLE,
        TX_WAIT
    } state_t;

    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
    localparam logic [6:0] FIRST_WR_L = 7'(FIRST_WR_ADDR);

    // The write-data timer is 16 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65536");
    end

    state_t     state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic       rx_ready_q, rx_ready_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic [6:0] reg_num_q, reg_num_d;
    logic       reg_write_q, reg_write_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       busy_q, busy_d;
    logic [7:0] err_count_q, err_count_d;
    logic       err_inc;
    logic       rx_accept;

    assign rx_accept = bus.rx_valid & rx_ready_q;

`ifdef REG_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timer_q, timer_d;

    // Counts cycles spent in WR_DATA; zero on the first cycle after entry.
    always_comb begin
        timer_d = 16'd0;
        if (state_q == WR_DATA) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        reg_num_d   = reg_num_q;
        reg_write_d = 1'b0;
        reg_wdata_d = reg_wdata_q;
        err_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_accept) begin
                    addr_d = bus.rx_data[6:0];
                    if (bus.rx_data[7]) begin
                        state_d = WR_DATA;
                    end else begin
                        // Present the read address early so RD_ADDR is a full settle cycle.
                        state_d   = RD_ADDR;
                        reg_num_d = bus.rx_data[6:0];
                    end
                end
            end
            WR_DATA: begin
                if (rx_accept) begin
                    if (addr_q >= FIRST_WR_L && addr_q <= MAX_ADDR_L) begin
                        state_d     = WR_STROBE;
                        reg_num_d   = addr_q;
                        reg_wdata_d = bus.rx_data;
                        reg_write_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end
                end
`ifdef REG_CMD_TIMEOUT_EN
                else if (timer_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end
`endif
            end
            WR_STROBE: begin
                state_d   = IDLE;
                reg_num_d = 7'd0;
            end
            RD_ADDR: begin
                state_d = RD_SAMPLE;
            end
            RD_SAMPLE: begin
                state_d    = TX_WAIT;
                tx_valid_d = 1'b1;
                reg_num_d  = 7'd0;
                if (addr_q <= MAX_ADDR_L) begin
                    tx_data_d = bus.reg_rdata;
                end else begin
                    tx_data_d = RD_ERR_BYTE;
                    err_inc   = 1'b1;
                end
            end
            TX_WAIT: begin
                if (bus.tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                reg_num_d  = 7'd0;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        rx_ready_d  = (state_d == IDLE) || (state_d == WR_DATA);
        busy_d      = (state_d != IDLE);
        err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 7'd0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            reg_num_q   <= 7'd0;
            reg_write_q <= 1'b0;
            reg_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            reg_num_q   <= reg_num_d;
            reg_write_q <= reg_write_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.reg_num   = reg_num_q;
    assign bus.reg_write = reg_write_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign busy          = busy_q;
    assign err_count     = err_count_q;

endmodule
